// File: rtl/wb_commit_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_queue
// Purpose  : Write-back commit queue in front of the 32x32 register bank.
//            Buffers datapath register writes and drives the bank write port
//            one entry per cycle in program order. Pending entries are
//            forwarded to the two bank read ports.
// Ports    : clk, rst_n           clock, async active-low reset
//            wb_valid/wb_ready    producer handshake (wb_ready is registered)
//            wb_en/wb_dir/wb_data write intent, destination, data
//            drain_en             bank write port available this cycle
//            Rw/Dir/DIn           bank write strobe/address/data
//            Rd1/Rd2              bank read addresses
//            Fw1_hit/Fw1_data     forwarding result for Rd1
//            Fw2_hit/Fw2_data     forwarding result for Rd2
//            count                number of pending entries
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_dir,
  input  logic [DW-1:0] wb_data,
  input  logic          drain_en,
  output logic          Rw,
  output logic [AW-1:0] Dir,
  output logic [DW-1:0] DIn,
  input  logic [AW-1:0] Rd1,
  input  logic [AW-1:0] Rd2,
  output logic          Fw1_hit,
  output logic [DW-1:0] Fw1_data,
  output logic          Fw2_hit,
  output logic [DW-1:0] Fw2_data,
  output logic [3:0]    count
);

  localparam int         c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] c_depth = 4'(DEPTH);

  logic [AW-1:0]      r_dir  [DEPTH];
  logic [DW-1:0]      r_data [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [3:0]         r_count;
  logic               r_ready;

  logic               w_push;
  logic               w_pop;
  logic [3:0]         w_count_nxt;

  // Offers with wb_en=0 or targeting R0 complete the handshake but are dropped.
  assign w_push      = wb_valid && r_ready && wb_en && (wb_dir != '0);
  assign w_pop       = (r_count != 4'd0) && drain_en;
  assign w_count_nxt = r_count + {3'b000, w_push} - {3'b000, w_pop};

  assign wb_ready = r_ready;
  assign count    = r_count;
  assign Rw       = w_pop;
  assign Dir      = w_pop ? r_dir[r_rd_ptr]  : '0;
  assign DIn      = w_pop ? r_data[r_rd_ptr] : '0;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dir[i]  <= '0;
          r_data[i] <= '0;
        end else if (w_push && (r_wr_ptr == c_ptr_w'(i))) begin
          r_dir[i]  <= wb_dir;
          r_data[i] <= wb_data;
        end
      end
    end
  endgenerate

  // wb_ready is computed from the post-edge occupancy so it is a pure flop
  // output; it comes up one edge after reset release since count is then 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < c_depth);
    end
  end

  // Walk entries oldest to youngest so a later match overrides an earlier
  // one, leaving the youngest matching entry's data on the output.
  always_comb begin
    logic [c_ptr_w-1:0] v_idx;
    v_idx    = '0;
    Fw1_hit  = 1'b0;
    Fw1_data = '0;
    Fw2_hit  = 1'b0;
    Fw2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_rd_ptr + c_ptr_w'(k);
      if (4'(k) < r_count) begin
        if ((Rd1 != '0) && (r_dir[v_idx] == Rd1)) begin
          Fw1_hit  = 1'b1;
          Fw1_data = r_data[v_idx];
        end
        if ((Rd2 != '0) && (r_dir[v_idx] == Rd2)) begin
          Fw2_hit  = 1'b1;
          Fw2_data = r_data[v_idx];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit_queue
// Purpose  : Self-checking bench for wb_commit_queue. Accepted writes that
//            must reach the bank are pushed into a scoreboard; a monitor pops
//            and compares on every bank write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_commit_queue;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_en;
  logic [4:0]  wb_dir;
  logic [31:0] wb_data;
  logic        drain_en;
  logic        Rw;
  logic [4:0]  Dir;
  logic [31:0] DIn;
  logic [4:0]  Rd1;
  logic [4:0]  Rd2;
  logic        Fw1_hit;
  logic [31:0] Fw1_data;
  logic        Fw2_hit;
  logic [31:0] Fw2_data;
  logic [3:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] sb [$];

  wb_commit_queue #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_en    (wb_en),
    .wb_dir   (wb_dir),
    .wb_data  (wb_data),
    .drain_en (drain_en),
    .Rw       (Rw),
    .Dir      (Dir),
    .DIn      (DIn),
    .Rd1      (Rd1),
    .Rd2      (Rd2),
    .Fw1_hit  (Fw1_hit),
    .Fw1_data (Fw1_data),
    .Fw2_hit  (Fw2_hit),
    .Fw2_data (Fw2_data),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every bank write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && Rw) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL commit_unexpected: got Dir=%0d DIn=0x%0h, expected no write", Dir, DIn);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        if ({Dir, DIn} !== e) begin
          n_fail++;
          $display("FAIL commit: got Dir=%0d DIn=0x%0h, expected Dir=%0d DIn=0x%0h",
                   Dir, DIn, e[36:32], e[31:0]);
        end
      end
    end
  end

  // Present an offer and hold it until accepted. Call #1 after a rising edge.
  task automatic offer(input logic en, input logic [4:0] dir, input logic [31:0] data,
                       input bit expect_commit);
    bit accepted;
    accepted = 0;
    wb_valid = 1'b1;
    wb_en    = en;
    wb_dir   = dir;
    wb_data  = data;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (wb_ready) begin
        @(posedge clk);
        #1;
        accepted = 1;
      end
    end
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("FAIL offer_timeout: got no acceptance, expected wb_ready within 50 cycles");
      @(posedge clk);
      #1;
    end else if (expect_commit) begin
      sb.push_back({dir, data});
    end
    wb_valid = 1'b0;
    wb_en    = 1'b0;
    wb_dir   = '0;
    wb_data  = '0;
  endtask

  task automatic wait_empty(input string name);
    int i;
    i = 0;
    while ((count != 4'd0 || sb.size() != 0) && i < 50) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk({name, "_drained_count"}, 32'(count), 32'd0);
    chk({name, "_drained_sb"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_valid = 1'b0;
    wb_en    = 1'b0;
    wb_dir   = '0;
    wb_data  = '0;
    drain_en = 1'b0;
    Rd1      = '0;
    Rd2      = '0;

    // Reset state
    #2;
    chk("rst_Rw", 32'(Rw), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(wb_ready), 32'd0);
    chk("rst_Dir", 32'(Dir), 32'd0);
    chk("rst_DIn", DIn, 32'd0);
    chk("rst_fw1", {31'd0, Fw1_hit} | Fw1_data, 32'd0);
    #10 rst_n = 1'b1;
    #1;
    chk("rst_ready_before_edge", 32'(wb_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_ready_after_edge", 32'(wb_ready), 32'd1);

    // T1: reset with two pending writes discards them
    offer(1'b1, 5'd1, 32'h1, 1'b0);
    offer(1'b1, 5'd2, 32'h2, 1'b0);
    chk("t1_count_full", 32'(count), 32'd2);
    chk("t1_ready_full", 32'(wb_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_Rw", 32'(Rw), 32'd0);
    chk("t1_rst_count", 32'(count), 32'd0);
    chk("t1_rst_ready", 32'(wb_ready), 32'd0);
    #2 rst_n = 1'b1;
    drain_en = 1'b1;
    #1;
    chk("t1_ready_before_edge", 32'(wb_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_ready_after_edge", 32'(wb_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_count_stays_0", 32'(count), 32'd0);

    // T2: single write commits the cycle after acceptance
    offer(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    chk("t2_Rw_next_cycle", 32'(Rw), 32'd1);
    chk("t2_Dir", 32'(Dir), 32'd5);
    @(posedge clk);
    #1;
    chk("t2_count_after", 32'(count), 32'd0);
    chk("t2_Rw_one_cycle", 32'(Rw), 32'd0);

    // T3: fill, hold a third offer, then drain in order
    drain_en = 1'b0;
    offer(1'b1, 5'd3, 32'h11, 1'b1);
    offer(1'b1, 5'd4, 32'h22, 1'b1);
    chk("t3_count_full", 32'(count), 32'd2);
    chk("t3_ready_full", 32'(wb_ready), 32'd0);
    fork
      offer(1'b1, 5'd6, 32'h33, 1'b1);
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("t3_held_count", 32'(count), 32'd2);
        chk("t3_held_ready", 32'(wb_ready), 32'd0);
        drain_en = 1'b1;
      end
    join
    wait_empty("t3");

    // T4: forwarding picks the youngest match
    drain_en = 1'b0;
    offer(1'b1, 5'd7, 32'hA, 1'b1);
    offer(1'b1, 5'd7, 32'hB, 1'b1);
    Rd1 = 5'd7;
    Rd2 = 5'd0;
    #1;
    chk("t4_fw1_hit", 32'(Fw1_hit), 32'd1);
    chk("t4_fw1_data", Fw1_data, 32'hB);
    chk("t4_fw2_hit", 32'(Fw2_hit), 32'd0);
    chk("t4_fw2_data", Fw2_data, 32'd0);
    Rd2 = 5'd3;
    #1;
    chk("t4_fw2_miss", {31'd0, Fw2_hit} | Fw2_data, 32'd0);
    drain_en = 1'b1;
    #1;
    chk("t4_fw1_hit_while_commit", 32'(Fw1_hit), 32'd1);
    chk("t4_fw1_data_while_commit", Fw1_data, 32'hB);
    wait_empty("t4");
    chk("t4_fw1_after_drain", {31'd0, Fw1_hit} | Fw1_data, 32'd0);
    Rd1 = 5'd0;
    Rd2 = 5'd0;

    // T5: R0 and wb_en=0 offers are consumed but never queued
    offer(1'b1, 5'd0, 32'hFFFF, 1'b0);
    chk("t5_count_r0", 32'(count), 32'd0);
    offer(1'b0, 5'd9, 32'h1234, 1'b0);
    chk("t5_count_noen", 32'(count), 32'd0);
    chk("t5_ready", 32'(wb_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_count_final", 32'(count), 32'd0);

    // T6: simultaneous push and pop
    drain_en = 1'b0;
    offer(1'b1, 5'd2, 32'h5, 1'b1);
    chk("t6_count_1", 32'(count), 32'd1);
    drain_en = 1'b1;
    #1;
    chk("t6_Rw_head", 32'(Rw), 32'd1);
    chk("t6_Dir_head", 32'(Dir), 32'd2);
    offer(1'b1, 5'd8, 32'h6, 1'b1);
    chk("t6_count_unchanged", 32'(count), 32'd1);
    chk("t6_Dir_next", 32'(Dir), 32'd8);
    chk("t6_DIn_next", DIn, 32'h6);
    wait_empty("t6");

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
